// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests, and buffers returned words
// with their PC in a small queue toward decode. A flush drops the queue and in-flight responses.
module fetch_queue #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_v_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_req_rdy_i,
  input  logic            imem_rsp_v_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            flush_v_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            instr_v_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_fault_o,
  input  logic            dec_rdy_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q;
  logic [XLEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic            q_err  [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, outstanding_q, discard_q;
  logic [UW-1:0]   credit_use;
  logic [XLEN-1:0] flush_target;
  logic            empty, deq, req_accept, enq;
  logic            unused_flush_bits;

  assign unused_flush_bits = ^flush_pc_i[1:0];
  assign flush_target      = {flush_pc_i[XLEN-1:2], 2'b00};

  assign empty      = (count_q == '0);
  assign instr_v_o  = ~empty & ~flush_v_i;
  assign deq        = instr_v_o & dec_rdy_i;
  assign enq        = imem_rsp_v_i & ~flush_v_i & (discard_q == '0);

  // Credits cover both queued words and requests still in flight, including ones
  // that will be discarded; the same-cycle dequeue frees a slot early.
  assign credit_use   = UW'(outstanding_q) + UW'(count_q) - UW'(deq);
  assign imem_req_v_o = (state_q == RUN) & ~flush_v_i & (credit_use < UW'(DEPTH));
  assign req_accept   = imem_req_v_o & imem_req_rdy_i;
  assign imem_adr_o   = fetch_pc_q;

  assign instr_o       = instr_v_o ? q_data[rd_ptr_q] : '0;
  assign pc_o          = instr_v_o ? q_pc[rd_ptr_q]   : '0;
  assign instr_fault_o = instr_v_o & q_err[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (enq && imem_rsp_err_i) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (flush_v_i) state_d = RUN;
  end

  // A flush keeps counting in-flight requests as outstanding and marks them all for discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q <= state_d;
      if (flush_v_i) begin
        fetch_pc_q    <= flush_target;
        rsp_pc_q      <= flush_target;
        rd_ptr_q      <= '0;
        wr_ptr_q      <= '0;
        count_q       <= '0;
        outstanding_q <= outstanding_q - CW'(imem_rsp_v_i);
        discard_q     <= outstanding_q - CW'(imem_rsp_v_i);
      end else begin
        if (req_accept) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        outstanding_q <= outstanding_q + CW'(req_accept) - CW'(imem_rsp_v_i);
        if (imem_rsp_v_i && (discard_q != '0)) discard_q <= discard_q - CW'(1);
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
          rsp_pc_q <= rsp_pc_q + XLEN'(4);
        end
        if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_data[wr_ptr_q] <= imem_rsp_err_i ? '0 : imem_rsp_data_i;
      q_pc[wr_ptr_q]   <= rsp_pc_q;
      q_err[wr_ptr_q]  <= imem_rsp_err_i;
    end
  end

  rsp_no_overflow: assert property (@(posedge clk) disable iff (reset) enq |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against
// an in-order memory model and a queue-of-PCs reference for what decode should see.
module tb_fetch_queue;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h8000_0000;

  logic        clk, reset;
  logic        imem_req_v_o, imem_req_rdy_i, imem_rsp_v_i, imem_rsp_err_i;
  logic        flush_v_i, instr_v_o, instr_fault_o, dec_rdy_i;
  logic [31:0] imem_adr_o, imem_rsp_data_i, flush_pc_i, instr_o, pc_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_adr[$];
  logic [31:0] mem_exp[$];
  int          mem_due[$];
  int          mem_epoch[$];
  logic [31:0] model_q[$];
  int          epoch, cyc;
  bit          halted, boot;
  logic [31:0] exp_req;
  int          lat_min = 1, lat_max = 1, rsp_prob = 100, fault_mode = 0;
  logic [31:0] fault_adr = '0;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .imem_req_v_o(imem_req_v_o), .imem_adr_o(imem_adr_o), .imem_req_rdy_i(imem_req_rdy_i),
    .imem_rsp_v_i(imem_rsp_v_i), .imem_rsp_data_i(imem_rsp_data_i), .imem_rsp_err_i(imem_rsp_err_i),
    .flush_v_i(flush_v_i), .flush_pc_i(flush_pc_i),
    .instr_v_o(instr_v_o), .instr_o(instr_o), .pc_o(pc_o), .instr_fault_o(instr_fault_o),
    .dec_rdy_i(dec_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mem_fault(input logic [31:0] a);
    if (fault_mode == 1) return a == fault_adr;
    if (fault_mode == 2) return a[6:2] == 5'h13;
    return 1'b0;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    dec_rdy_i = 1'b0; imem_req_rdy_i = 1'b0; flush_v_i = 1'b0; flush_pc_i = '0;
    imem_rsp_v_i = 1'b0; imem_rsp_data_i = '0; imem_rsp_err_i = 1'b0;
    mem_adr.delete(); mem_exp.delete(); mem_due.delete(); mem_epoch.delete(); model_q.delete();
    epoch = 0; halted = 0; boot = 1; exp_req = RV;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one cycle's inputs shortly after the rising edge; outputs are sampled by the caller afterwards.
  task automatic begin_cycle(input bit dec, input bit rdy, input bit fl, input logic [31:0] fpc);
    #1;
    dec_rdy_i = dec; imem_req_rdy_i = rdy; flush_v_i = fl; flush_pc_i = fpc;
    if (mem_adr.size() > 0 && mem_due[0] <= cyc && $urandom_range(99) < rsp_prob) begin
      imem_rsp_v_i    = 1'b1;
      imem_rsp_data_i = mem_word(mem_adr[0]);
      imem_rsp_err_i  = mem_fault(mem_adr[0]);
    end else begin
      imem_rsp_v_i    = 1'b0;
      imem_rsp_data_i = $urandom;
      imem_rsp_err_i  = 1'($urandom_range(1));
    end
    #1;
  endtask

  task automatic end_cycle();
    bit acc, deq;
    acc = imem_req_v_o && imem_req_rdy_i;
    deq = instr_v_o && dec_rdy_i;
    if (deq && model_q.size() > 0) void'(model_q.pop_front());
    if (imem_rsp_v_i) begin
      if (!flush_v_i && mem_epoch[0] == epoch) begin
        model_q.push_back(mem_exp[0]);
        if (mem_fault(mem_exp[0])) halted = 1;
      end
      void'(mem_adr.pop_front()); void'(mem_exp.pop_front());
      void'(mem_due.pop_front()); void'(mem_epoch.pop_front());
    end
    if (acc) begin
      mem_adr.push_back(imem_adr_o);
      mem_exp.push_back(exp_req);
      mem_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      mem_epoch.push_back(epoch);
      exp_req = exp_req + 32'd4;
    end
    if (flush_v_i) begin
      model_q.delete();
      epoch++;
      exp_req = {flush_pc_i[31:2], 2'b00};
      halted = 0;
    end
    boot = 0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dec_rdy_i = 1'b1; imem_req_rdy_i = 1'b1; flush_v_i = 1'b0; flush_pc_i = '0;
    imem_rsp_v_i = 1'b0; imem_rsp_data_i = '0; imem_rsp_err_i = 1'b0;
    #7;
    checks += 6;
    if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_v got=%b exp=0", imem_req_v_o); end
    if (imem_adr_o !== RV) begin errors++; $display("[TB] FAIL rst_adr got=%h exp=%h", imem_adr_o, RV); end
    if (instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_instr_v got=%b exp=0", instr_v_o); end
    if (instr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got=%h exp=0", instr_o); end
    if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc got=%h exp=0", pc_o); end
    if (instr_fault_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got=%b exp=0", instr_fault_o); end
    apply_reset();
    begin_cycle(1, 1, 0, 0);
    checks++;
    if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL boot_req_v got=%b exp=0", imem_req_v_o); end
    end_cycle();
  endtask

  task automatic test_stream();
    logic [31:0] e;
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 100; fault_mode = 0;
    for (int k = 0; k < 12; k++) begin
      begin_cycle(1, 1, 0, 0);
      checks += 2;
      if (imem_req_v_o !== (k >= 1)) begin errors++; $display("[TB] FAIL stream_req_v k=%0d got=%b", k, imem_req_v_o); end
      if (instr_v_o !== (k >= 3)) begin errors++; $display("[TB] FAIL stream_instr_v k=%0d got=%b", k, instr_v_o); end
      if (k >= 1) begin
        e = RV + 32'(4 * (k - 1));
        checks++;
        if (imem_adr_o !== e) begin errors++; $display("[TB] FAIL stream_adr k=%0d got=%h exp=%h", k, imem_adr_o, e); end
      end
      if (k >= 3) begin
        e = RV + 32'(4 * (k - 3));
        checks += 2;
        if (pc_o !== e) begin errors++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, pc_o, e); end
        if (instr_o !== mem_word(e)) begin errors++; $display("[TB] FAIL stream_instr k=%0d got=%h exp=%h", k, instr_o, mem_word(e)); end
      end
      end_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 100; fault_mode = 0;
    for (int k = 0; k < 8; k++) begin
      begin_cycle(0, 1, 0, 0);
      if (k >= 3) begin
        checks += 4;
        if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_v k=%0d got=%b exp=0", k, imem_req_v_o); end
        if (instr_v_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_instr_v k=%0d got=%b exp=1", k, instr_v_o); end
        if (pc_o !== RV) begin errors++; $display("[TB] FAIL bp_hold_pc k=%0d got=%h exp=%h", k, pc_o, RV); end
        if (instr_o !== mem_word(RV)) begin errors++; $display("[TB] FAIL bp_hold_instr k=%0d got=%h exp=%h", k, instr_o, mem_word(RV)); end
      end
      end_cycle();
    end
    for (int j = 0; j < 10; j++) begin
      begin_cycle(1, 1, 0, 0);
      e = RV + 32'(4 * j);
      checks += 2;
      if (instr_v_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_v j=%0d got=%b exp=1", j, instr_v_o); end
      if (pc_o !== e) begin errors++; $display("[TB] FAIL bp_resume_pc j=%0d got=%h exp=%h", j, pc_o, e); end
      end_cycle();
    end
  endtask

  task automatic test_flush_inflight();
    bit got_req, got_ins;
    apply_reset();
    lat_min = 3; lat_max = 3; rsp_prob = 100; fault_mode = 0;
    for (int k = 0; k < 3; k++) begin
      begin_cycle(1, 1, 0, 0);
      end_cycle();
    end
    begin_cycle(1, 1, 1, 32'h0000_0106);
    checks += 2;
    if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_req_v got=%b exp=0", imem_req_v_o); end
    if (instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_instr_v got=%b exp=0", instr_v_o); end
    end_cycle();
    got_req = 0; got_ins = 0;
    for (int k = 0; k < 20 && !(got_req && got_ins); k++) begin
      begin_cycle(1, 1, 0, 0);
      if (!got_req && imem_req_v_o) begin
        got_req = 1; checks++;
        if (imem_adr_o !== 32'h0000_0104) begin errors++; $display("[TB] FAIL fl_new_adr got=%h exp=00000104", imem_adr_o); end
      end
      if (!got_ins && instr_v_o) begin
        got_ins = 1; checks += 2;
        if (pc_o !== 32'h0000_0104) begin errors++; $display("[TB] FAIL fl_first_pc got=%h exp=00000104", pc_o); end
        if (instr_o !== mem_word(32'h104)) begin errors++; $display("[TB] FAIL fl_first_instr got=%h exp=%h", instr_o, mem_word(32'h104)); end
      end
      end_cycle();
    end
    checks++;
    if (!(got_req && got_ins)) begin errors++; $display("[TB] FAIL fl_timeout got_req=%0b got_ins=%0b exp=1/1", got_req, got_ins); end
  endtask

  task automatic test_fault();
    bit found, got_req, got_ins;
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 100; fault_mode = 1; fault_adr = RV + 32'd8;
    found = 0;
    for (int k = 0; k < 15 && !found; k++) begin
      begin_cycle(1, 1, 0, 0);
      if (instr_v_o && pc_o == RV + 32'd8) begin
        found = 1; checks += 2;
        if (instr_fault_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_flag got=%b exp=1", instr_fault_o); end
        if (instr_o !== 32'h0) begin errors++; $display("[TB] FAIL fault_instr got=%h exp=0", instr_o); end
      end
      end_cycle();
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL fault_timeout got=0 exp=1"); end
    for (int k = 0; k < 6; k++) begin
      begin_cycle(1, 1, 0, 0);
      checks++;
      if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_v k=%0d got=%b exp=0", k, imem_req_v_o); end
      end_cycle();
    end
    begin_cycle(1, 1, 1, 32'h8000_0100);
    end_cycle();
    got_req = 0; got_ins = 0;
    for (int k = 0; k < 10 && !(got_req && got_ins); k++) begin
      begin_cycle(1, 1, 0, 0);
      if (!got_req && imem_req_v_o) begin
        got_req = 1; checks++;
        if (imem_adr_o !== 32'h8000_0100) begin errors++; $display("[TB] FAIL resume_adr got=%h exp=80000100", imem_adr_o); end
      end
      if (!got_ins && instr_v_o) begin
        got_ins = 1; checks += 2;
        if (pc_o !== 32'h8000_0100) begin errors++; $display("[TB] FAIL resume_pc got=%h exp=80000100", pc_o); end
        if (instr_fault_o !== 1'b0) begin errors++; $display("[TB] FAIL resume_fault got=%b exp=0", instr_fault_o); end
      end
      end_cycle();
    end
    checks++;
    if (!(got_req && got_ins)) begin errors++; $display("[TB] FAIL resume_timeout got_req=%0b got_ins=%0b exp=1/1", got_req, got_ins); end
    fault_mode = 0;
  endtask

  task automatic test_flush_collide();
    bit got_ins;
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 100; fault_mode = 0;
    for (int k = 0; k < 6; k++) begin
      begin_cycle(1, 1, 0, 0);
      end_cycle();
    end
    begin_cycle(1, 1, 1, 32'h0000_2000);
    checks += 3;
    if (imem_rsp_v_i !== 1'b1) begin errors++; $display("[TB] FAIL col_setup_rsp got=%b exp=1", imem_rsp_v_i); end
    if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL col_req_v got=%b exp=0", imem_req_v_o); end
    if (instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL col_instr_v got=%b exp=0", instr_v_o); end
    end_cycle();
    begin_cycle(1, 1, 0, 0);
    checks += 2;
    if (imem_req_v_o !== 1'b1) begin errors++; $display("[TB] FAIL col_next_req_v got=%b exp=1", imem_req_v_o); end
    if (imem_adr_o !== 32'h0000_2000) begin errors++; $display("[TB] FAIL col_next_adr got=%h exp=00002000", imem_adr_o); end
    end_cycle();
    got_ins = 0;
    for (int k = 0; k < 8 && !got_ins; k++) begin
      begin_cycle(1, 1, 0, 0);
      if (instr_v_o) begin
        got_ins = 1; checks++;
        if (pc_o !== 32'h0000_2000) begin errors++; $display("[TB] FAIL col_first_pc got=%h exp=00002000", pc_o); end
      end
      end_cycle();
    end
    checks++;
    if (!got_ins) begin errors++; $display("[TB] FAIL col_timeout got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lat_min = 1; lat_max = 1; rsp_prob = 100; fault_mode = 0;
    for (int k = 0; k < 8; k++) begin
      begin_cycle(0, 1, 0, 0);
      end_cycle();
    end
    #3 reset = 1'b1;
    #1;
    checks += 6;
    if (imem_req_v_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_v got=%b exp=0", imem_req_v_o); end
    if (imem_adr_o !== RV) begin errors++; $display("[TB] FAIL mid_adr got=%h exp=%h", imem_adr_o, RV); end
    if (instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_instr_v got=%b exp=0", instr_v_o); end
    if (instr_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_instr got=%h exp=0", instr_o); end
    if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_pc got=%h exp=0", pc_o); end
    if (instr_fault_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_fault got=%b exp=0", instr_fault_o); end
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      begin_cycle(1, 1, 0, 0);
      if (k == 1) begin
        checks += 2;
        if (imem_req_v_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_req got=%b exp=1", imem_req_v_o); end
        if (imem_adr_o !== RV) begin errors++; $display("[TB] FAIL mid_restart_adr got=%h exp=%h", imem_adr_o, RV); end
      end
      if (k == 3) begin
        checks += 2;
        if (instr_v_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_v got=%b exp=1", instr_v_o); end
        if (pc_o !== RV) begin errors++; $display("[TB] FAIL mid_restart_pc got=%h exp=%h", pc_o, RV); end
      end
      end_cycle();
    end
  endtask

  // Randomized traffic: the model predicts decode-side outputs from a queue of expected PCs and
  // request eligibility from in-flight count plus queue occupancy.
  task automatic test_random();
    int lmin[4] = '{1, 1, 2, 1};
    int lmax[4] = '{1, 3, 4, 2};
    int rprb[4] = '{100, 70, 50, 90};
    int aprb[4] = '{100, 80, 60, 90};
    int dprb[4] = '{100, 70, 50, 30};
    int fmod[4] = '{0, 2, 2, 0};
    bit dec, rdy, fl, exp_v, exp_rv, ef;
    logic [31:0] fpc, epc, ein;
    int halted_cnt, delivered;
    for (int p = 0; p < 4; p++) begin
      apply_reset();
      lat_min = lmin[p]; lat_max = lmax[p]; rsp_prob = rprb[p]; fault_mode = fmod[p];
      halted_cnt = 0; delivered = 0;
      for (int c = 0; c < 700; c++) begin
        dec = $urandom_range(99) < dprb[p];
        rdy = $urandom_range(99) < aprb[p];
        fl  = ($urandom_range(19) == 0) || (halted_cnt > 5);
        fpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        begin_cycle(dec, rdy, fl, fpc);
        exp_v = (model_q.size() > 0) && !fl;
        epc = exp_v ? model_q[0] : 32'h0;
        ef  = exp_v && mem_fault(epc);
        ein = (exp_v && !ef) ? mem_word(epc) : 32'h0;
        exp_rv = !boot && !halted && !fl &&
                 (mem_adr.size() + model_q.size() - int'(exp_v && dec) < DEPTH);
        checks += 5;
        if (instr_v_o !== exp_v) begin errors++; $display("[TB] FAIL rnd_instr_v p=%0d c=%0d got=%b exp=%b", p, c, instr_v_o, exp_v); end
        if (pc_o !== epc) begin errors++; $display("[TB] FAIL rnd_pc p=%0d c=%0d got=%h exp=%h", p, c, pc_o, epc); end
        if (instr_o !== ein) begin errors++; $display("[TB] FAIL rnd_instr p=%0d c=%0d got=%h exp=%h", p, c, instr_o, ein); end
        if (instr_fault_o !== ef) begin errors++; $display("[TB] FAIL rnd_fault p=%0d c=%0d got=%b exp=%b", p, c, instr_fault_o, ef); end
        if (imem_req_v_o !== exp_rv) begin errors++; $display("[TB] FAIL rnd_req_v p=%0d c=%0d got=%b exp=%b", p, c, imem_req_v_o, exp_rv); end
        if (exp_rv) begin
          checks++;
          if (imem_adr_o !== exp_req) begin errors++; $display("[TB] FAIL rnd_adr p=%0d c=%0d got=%h exp=%h", p, c, imem_adr_o, exp_req); end
        end
        if (exp_v && dec) delivered++;
        end_cycle();
        halted_cnt = halted ? halted_cnt + 1 : 0;
      end
      checks++;
      if (delivered < 20) begin errors++; $display("[TB] FAIL rnd_progress p=%0d got=%0d exp>=20", p, delivered); end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_fault();
    test_flush_collide();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
